// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/WB sequencer for an RV32I R-type/OP-IMM datapath.
// Drives PC/regfile enables, ALU op and B-operand select; ECALL halts, bad opcodes and fetch timeouts fault.
module multicycle_ctrl #(
  parameter int IMEM_WAIT_MAX = 15,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             imem_req,
  input  logic             imem_ack,
  input  logic [31:0]      instr,
  output logic             ir_we,
  output logic             pc_we,
  output logic             reg_wr,
  output logic             src_b_sel,
  output logic [3:0]       alu_op,
  output logic [CNT_W-1:0] retired,
  output logic [1:0]       fault,
  output logic             halted
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_FAULT
  } state_t;

  localparam logic [6:0]  OP_R          = 7'b0110011;
  localparam logic [6:0]  OP_IMM        = 7'b0010011;
  localparam logic [31:0] ECALL_WORD    = 32'h0000_0073;
  localparam logic [1:0]  FAULT_NONE    = 2'b00;
  localparam logic [1:0]  FAULT_ILLEGAL = 2'b01;
  localparam logic [1:0]  FAULT_TIMEOUT = 2'b10;

  // The counter only has to hold 0 .. IMEM_WAIT_MAX-1; the last no-ack cycle faults directly.
  localparam int                WAIT_W    = (IMEM_WAIT_MAX < 2) ? 1 : $clog2(IMEM_WAIT_MAX);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(IMEM_WAIT_MAX - 1);

  state_t            r_state;
  logic [WAIT_W-1:0] r_wait;
  logic [6:0]        r_opcode;
  logic [2:0]        r_funct3;
  logic              r_alt;
  logic              r_rd_nz;
  logic              r_ecall;
  logic              r_imem_req;
  logic              r_pc_we;
  logic              r_reg_wr;
  logic              r_src_b_sel;
  logic [3:0]        r_alu_op;
  logic [CNT_W-1:0]  r_retired;
  logic [1:0]        r_fault;
  logic              r_halted;

  logic       w_is_imm;
  logic       w_legal;
  logic [3:0] w_alu_op;

  assign w_is_imm = (r_opcode == OP_IMM);
  assign w_legal  = (r_opcode == OP_R) || w_is_imm;
  // Immediate forms only honour funct7[5] for shifts (SRAI); ADDI must never become SUB.
  assign w_alu_op = {(w_is_imm ? ((r_funct3 == 3'b101) && r_alt) : r_alt), r_funct3};

  // NOTE: all state and outputs update with non-blocking assignments in this one clocked block, so
  // every branch below reads the pre-edge values and the output registers always match r_state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_wait      <= '0;
      r_opcode    <= '0;
      r_funct3    <= '0;
      r_alt       <= 1'b0;
      r_rd_nz     <= 1'b0;
      r_ecall     <= 1'b0;
      r_imem_req  <= 1'b0;
      r_pc_we     <= 1'b0;
      r_reg_wr    <= 1'b0;
      r_src_b_sel <= 1'b0;
      r_alu_op    <= '0;
      r_retired   <= '0;
      r_fault     <= FAULT_NONE;
      r_halted    <= 1'b1;
    end else begin
      r_pc_we  <= 1'b0;
      r_reg_wr <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state    <= S_FETCH;
            r_imem_req <= 1'b1;
            r_halted   <= 1'b0;
          end
        end
        S_FETCH: begin
          if (imem_ack) begin
            r_opcode   <= instr[6:0];
            r_funct3   <= instr[14:12];
            r_alt      <= instr[30];
            r_rd_nz    <= (instr[11:7] != 5'd0);
            r_ecall    <= (instr == ECALL_WORD);
            r_wait     <= '0;
            r_state    <= S_DECODE;
            r_imem_req <= 1'b0;
          end else if (r_wait == WAIT_LAST) begin
            r_wait     <= '0;
            r_fault    <= FAULT_TIMEOUT;
            r_state    <= S_FAULT;
            r_imem_req <= 1'b0;
            r_halted   <= 1'b1;
          end else begin
            r_wait <= r_wait + WAIT_W'(1);
          end
        end
        S_DECODE: begin
          if (w_legal) begin
            r_state     <= S_EXEC;
            r_src_b_sel <= w_is_imm;
            r_alu_op    <= w_alu_op;
          end else if (r_ecall) begin
            r_retired <= r_retired + CNT_W'(1);
            r_state   <= S_IDLE;
            r_halted  <= 1'b1;
          end else begin
            r_fault  <= FAULT_ILLEGAL;
            r_state  <= S_FAULT;
            r_halted <= 1'b1;
          end
        end
        S_EXEC: begin
          r_state  <= S_WB;
          r_pc_we  <= 1'b1;
          r_reg_wr <= r_rd_nz;
        end
        S_WB: begin
          r_retired  <= r_retired + CNT_W'(1);
          r_state    <= S_FETCH;
          r_imem_req <= 1'b1;
        end
        S_FAULT: begin
          if (start) begin
            r_fault    <= FAULT_NONE;
            r_state    <= S_FETCH;
            r_imem_req <= 1'b1;
            r_halted   <= 1'b0;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_imem_req <= 1'b0;
          r_halted   <= 1'b1;
        end
      endcase
    end
  end

  // ir_we is the one combinational output so the IR captures in the same cycle the ack arrives.
  assign ir_we     = r_imem_req && imem_ack;
  assign imem_req  = r_imem_req;
  assign pc_we     = r_pc_we;
  assign reg_wr    = r_reg_wr;
  assign src_b_sel = r_src_b_sel;
  assign alu_op    = r_alu_op;
  assign retired   = r_retired;
  assign fault     = r_fault;
  assign halted    = r_halted;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed literal checks followed by randomized stimulus, with a
// per-instruction behavioural model compared against every output on every falling edge.
module tb_multicycle_ctrl;

  localparam int WAIT_MAX = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        imem_ack = 1'b0;
  logic [31:0] instr = '0;
  logic        imem_req, ir_we, pc_we, reg_wr, src_b_sel, halted;
  logic [3:0]  alu_op;
  logic [31:0] retired;
  logic [1:0]  fault;

  int checks = 0;
  int errors = 0;

  multicycle_ctrl #(.IMEM_WAIT_MAX(WAIT_MAX), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .imem_req(imem_req), .imem_ack(imem_ack),
    .instr(instr), .ir_we(ir_we), .pc_we(pc_we), .reg_wr(reg_wr), .src_b_sel(src_b_sel),
    .alu_op(alu_op), .retired(retired), .fault(fault), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: is the core running, which step of the current instruction it is in
  // (0 fetch, 1 decode, 2 execute, 3 write-back), and the captured instruction word.
  bit          m_run;
  int          m_step;
  int          m_wait;
  logic [31:0] m_ir;
  logic [31:0] m_ret;
  logic [1:0]  m_fault;

  function automatic logic [4:0] exp_exec(input logic [31:0] w);  // {src_b_sel, alu_op}
    logic       is_imm;
    logic [2:0] f3;
    logic       alt;
    is_imm = (w[6:0] == 7'b0010011);
    f3     = w[14:12];
    alt    = is_imm ? (f3 == 3'b101 && w[30]) : w[30];
    return {is_imm, alt, f3};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run = 0; m_step = 0; m_wait = 0; m_ir = '0; m_ret = '0; m_fault = 2'b00;
    end else if (!m_run) begin
      if (start) begin
        m_run = 1; m_step = 0; m_wait = 0; m_fault = 2'b00;
      end
    end else begin
      case (m_step)
        0: if (imem_ack) begin
             m_ir = instr; m_step = 1; m_wait = 0;
           end else begin
             m_wait++;
             if (m_wait == WAIT_MAX) begin
               m_run = 0; m_fault = 2'b10; m_wait = 0;
             end
           end
        1: if (m_ir[6:0] == 7'b0110011 || m_ir[6:0] == 7'b0010011) m_step = 2;
           else if (m_ir == 32'h0000_0073) begin m_ret++; m_run = 0; end
           else begin m_fault = 2'b01; m_run = 0; end
        2: m_step = 3;
        default: begin m_ret++; m_step = 0; end
      endcase
    end
  end

  // Compare process: every output, every cycle.
  always @(negedge clk) begin
    logic [5:0] exp_ctl;
    logic       in_fetch, in_wb;
    in_fetch = m_run && m_step == 0;
    in_wb    = m_run && m_step == 3;
    exp_ctl  = {in_fetch, in_fetch && imem_ack, in_wb, in_wb && (m_ir[11:7] != 5'd0), !m_run, 1'b0};
    check("ctl{req,ir_we,pc_we,reg_wr,halted}",
          32'({imem_req, ir_we, pc_we, reg_wr, halted, 1'b0}), 32'(exp_ctl));
    check("fault", 32'(fault), 32'(m_fault));
    check("retired", retired, m_ret);
    if (m_run && m_step >= 2)
      check("exec{src_b_sel,alu_op}", 32'({src_b_sel, alu_op}), 32'(exp_exec(m_ir)));
  end

  task automatic tick(input logic s, input logic a, input logic [31:0] w);
    @(posedge clk);
    #2;
    start = s; imem_ack = a; instr = w;
    @(negedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom();
    case ($urandom_range(0, 9))
      0, 1, 2, 3: return {r[31:7], 7'b0110011};
      4, 5, 6:    return {r[31:7], 7'b0010011};
      7:          return 32'h0000_0073;
      8:          return {r[31:7], 7'b0000011};
      default:    return 32'h0010_0073;
    endcase
  endfunction

  localparam logic [31:0] ADD   = 32'h0020_81B3;
  localparam logic [31:0] SUB   = 32'h4020_81B3;
  localparam logic [31:0] ADDI  = 32'h0050_8093;
  localparam logic [31:0] SRAI  = 32'h4020_D093;
  localparam logic [31:0] ADDX0 = 32'h0020_8033;
  localparam logic [31:0] ECALL = 32'h0000_0073;
  localparam logic [31:0] LW    = 32'h0000_A083;

  initial begin
    int ack_pct;
    #12;
    check("rst halted", 32'(halted), 32'd1);
    check("rst imem_req", 32'(imem_req), 32'd0);
    check("rst alu_op/src_b", 32'({src_b_sel, alu_op}), 32'd0);
    check("rst retired", retired, 32'd0);
    @(posedge clk); #2 rst_n = 1'b1;

    // add x3,x1,x2 with zero-wait ack
    tick(1, 0, 0);        check("idle halted", 32'(halted), 32'd1);
    tick(0, 1, ADD);      check("fetch ir_we", 32'({imem_req, ir_we}), 32'b11);
    tick(0, 0, 0);        check("decode req", 32'(imem_req), 32'd0);
    tick(0, 0, 0);        check("add exec", 32'({src_b_sel, alu_op}), 32'b0_0000);
    tick(0, 0, 0);        check("add wb", 32'({pc_we, reg_wr}), 32'b11);
    tick(0, 1, SUB);      check("cycle5 req", 32'({imem_req, pc_we}), 32'b10);
    check("add retired", retired, 32'd1);
    check("model retired", m_ret, 32'd1);
    tick(0, 0, 0); tick(0, 0, 0);
    check("sub exec", 32'({src_b_sel, alu_op}), 32'b0_1000);
    tick(0, 0, 0); tick(0, 1, ADDI); tick(0, 0, 0); tick(0, 0, 0);
    check("addi exec", 32'({src_b_sel, alu_op}), 32'b1_0000);
    tick(0, 0, 0); tick(0, 1, SRAI); tick(0, 0, 0); tick(0, 0, 0);
    check("srai exec", 32'({src_b_sel, alu_op}), 32'b1_1101);
    tick(0, 0, 0); tick(0, 1, ADDX0); tick(0, 0, 0); tick(0, 0, 0); tick(0, 0, 0);
    check("x0 wb", 32'({pc_we, reg_wr}), 32'b10);

    // Fetch timeout
    for (int i = 0; i < WAIT_MAX; i++) tick(0, 0, 0);
    check("timeout last fetch", 32'({imem_req, fault}), 32'b1_00);
    tick(0, 0, 0);
    check("timeout fault", 32'({fault, halted, imem_req}), 32'b10_1_0);
    check("timeout retired", retired, 32'd5);
    check("model fault", 32'(m_fault), 32'd2);
    tick(1, 0, 0);
    tick(0, 1, ECALL);    check("restart fault clr", 32'({fault, ir_we}), 32'b00_1);
    tick(0, 0, 0);
    tick(0, 0, 0);        check("ecall idle", 32'({halted, pc_we}), 32'b10);
    check("ecall retired", retired, 32'd6);

    // Illegal opcode, and acks ignored while halted
    tick(1, 0, 0); tick(0, 1, LW); tick(0, 0, 0);
    tick(0, 1, 32'hFFFF_FFFF);
    check("illegal fault", 32'({fault, halted, ir_we, pc_we, reg_wr}), 32'b01_1_000);
    tick(1, 0, 0); tick(0, 1, ECALL); tick(0, 0, 0);
    tick(0, 1, ADD);      check("idle ack ignored", 32'({ir_we, halted}), 32'b01);
    check("idle retired", retired, 32'd7);

    // Ack on the final allowed wait cycle still captures
    tick(1, 0, 0);
    for (int i = 0; i < WAIT_MAX - 1; i++) tick(0, 0, 0);
    tick(0, 1, ADDI);     check("late ack ir_we", 32'({ir_we, fault}), 32'b1_00);
    tick(0, 0, 0);        check("late ack decode", 32'({fault, halted}), 32'b00_0);

    // Reset during EXEC
    tick(0, 0, 0); tick(0, 0, 0); tick(0, 1, ADD); tick(0, 0, 0); tick(0, 0, 0);
    check("pre-reset exec", 32'({src_b_sel, alu_op}), 32'b0_0000);
    rst_n = 1'b0;
    #1;
    check("mid rst ctl", 32'({imem_req, pc_we, reg_wr, halted, fault}), 32'b0001_00);
    check("mid rst retired", retired, 32'd0);
    @(posedge clk); #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(0, 1, ADD);
      check("post-rst quiet", 32'({pc_we, reg_wr, ir_we, halted}), 32'b0001);
    end

    // Randomized phase; per-segment ack probability exercises waits and timeouts.
    ack_pct = 50;
    for (int c = 0; c < 4000; c++) begin
      if (c % 250 == 0) begin
        case ($urandom_range(0, 3))
          0: ack_pct = 0;
          1: ack_pct = 20;
          2: ack_pct = 60;
          default: ack_pct = 100;
        endcase
      end
      @(posedge clk);
      #2;
      rst_n    = ($urandom_range(0, 399) != 0);
      start    = ($urandom_range(0, 99) < 30);
      imem_ack = ($urandom_range(0, 99) < ack_pct);
      instr    = rand_instr();
    end
    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
